// File: rtl/neuron_sched_if.sv
// neuron_sched_if: controller/core-side bundle of the neuron scheduler.
// master = layer controller + core; slave = neuron_sched.
interface neuron_sched_if #(
  parameter int IDX_W = 6,
  parameter int RES_W = 32
);
  logic             START;
  logic             ABORT;
  logic             BUSY;
  logic             DONE;
  logic [IDX_W-1:0] W_SEL;
  logic             ISSUE_VLD;
  logic             IMG_HOLD;
  logic [RES_W-1:0] CORE_RESULT;
  logic [IDX_W-1:0] RD_IDX;
  logic [RES_W-1:0] RD_DATA;
  logic [IDX_W-1:0] MAX_IDX;
  logic [RES_W-1:0] MAX_VAL;

  modport master (
    output START, ABORT, CORE_RESULT, RD_IDX,
    input  BUSY, DONE, W_SEL, ISSUE_VLD,
    input  IMG_HOLD, RD_DATA, MAX_IDX, MAX_VAL
  );

  modport slave (
    input  START, ABORT, CORE_RESULT, RD_IDX,
    output BUSY, DONE, W_SEL, ISSUE_VLD,
    output IMG_HOLD, RD_DATA, MAX_IDX, MAX_VAL
  );
endinterface

// File: rtl/neuron_sched.sv
// neuron_sched: time-multiplexes one pipelined mul_add_core over
// N_NEURON neurons and captures results into a result file.
// Ports: CLK, RESET (async, active-high), bus (neuron_sched_if.slave):
//   START/ABORT in, BUSY/DONE/ISSUE_VLD/IMG_HOLD out, W_SEL out,
//   CORE_RESULT in, RD_IDX in / RD_DATA out, MAX_IDX/MAX_VAL out.
// Optional: NEURON_SCHED_ARGMAX_EN enables the running argmax.
module neuron_sched #(
  parameter int N_NEURON = 46,
  parameter int IDX_W    = 6,
  parameter int CORE_LAT = 4,
  parameter int RES_W    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  neuron_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);
  localparam int PW = IDX_W + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] w_sel_q, w_sel_d;

  // {valid, index} delay line matching the core latency
  logic [PW-1:0]    pipe_q [CORE_LAT];
  logic [RES_W-1:0] res_q  [N_NEURON];

  logic             active;
  logic             kill;
  logic             dly_vld;
  logic [IDX_W-1:0] dly_idx;
  logic             cap_en;
  logic             issue_vld;

  assign active  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign kill    = active && bus.ABORT;
  assign dly_vld = pipe_q[CORE_LAT-1][IDX_W];
  assign dly_idx = pipe_q[CORE_LAT-1][IDX_W-1:0];
  // an abort also suppresses the capture in its own cycle
  assign cap_en  = dly_vld && !kill;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      w_sel_q <= '0;
    end else begin
      state_q <= state_d;
      w_sel_q <= w_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_sel_d = w_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_ISSUE;
          w_sel_d = '0;
        end
      end
      S_ISSUE: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (w_sel_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          w_sel_d = w_sel_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.ABORT) begin
          state_d = S_IDLE;
        end else if (dly_vld && dly_idx == LAST) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    issue_vld     = (state_q == S_ISSUE);
    bus.ISSUE_VLD = issue_vld;
    bus.W_SEL     = w_sel_q;
    bus.BUSY      = active;
    bus.IMG_HOLD  = active;
    bus.DONE      = (state_q == S_FIN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CORE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (kill) begin
      for (int i = 0; i < CORE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {issue_vld, w_sel_q};
      for (int i = 1; i < CORE_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_NEURON; i++) begin
        res_q[i] <= '0;
      end
    end else if (cap_en) begin
      res_q[dly_idx] <= bus.CORE_RESULT;
    end
  end

  always_comb begin
    bus.RD_DATA = '0;
    if (bus.RD_IDX <= LAST) begin
      bus.RD_DATA = res_q[bus.RD_IDX];
    end
  end

`ifdef NEURON_SCHED_ARGMAX_EN
  logic signed [RES_W-1:0] run_val_q, cand_val;
  logic [IDX_W-1:0]        run_idx_q, cand_idx;
  logic [RES_W-1:0]        max_val_q;
  logic [IDX_W-1:0]        max_idx_q;
  logic                    fin_edge;

  // neuron 0 seeds the run; strict > keeps the lowest index on ties
  always_comb begin
    cand_val = run_val_q;
    cand_idx = run_idx_q;
    if (cap_en) begin
      if (dly_idx == '0 ||
          $signed(bus.CORE_RESULT) > run_val_q) begin
        cand_val = $signed(bus.CORE_RESULT);
        cand_idx = dly_idx;
      end
    end
  end

  // published when the last capture moves the FSM into FIN
  assign fin_edge = (state_q == S_DRAIN) && (state_d == S_FIN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_val_q <= '0;
      run_idx_q <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      run_val_q <= cand_val;
      run_idx_q <= cand_idx;
      if (fin_edge) begin
        max_val_q <= cand_val;
        max_idx_q <= cand_idx;
      end
    end
  end

  assign bus.MAX_IDX = max_idx_q;
  assign bus.MAX_VAL = max_val_q;
`else
  assign bus.MAX_IDX = '0;
  assign bus.MAX_VAL = '0;
`endif

endmodule

// File: tb/tb_neuron_sched.sv
// tb_neuron_sched: directed self-checking bench for neuron_sched
// at CORE_LAT 4 (main), 1 and 16 (latency sweep).
module tb_neuron_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0;
  logic        abort_m = 1'b0;
  logic        start_l = 1'b0;
  logic [5:0]  rd_m = '0;
  logic [5:0]  rd_l = '0;
  int          mode = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] srm  [4];
  logic [31:0] sr1  [1];
  logic [31:0] sr16 [16];

  always #5 clk = ~clk;

  neuron_sched_if #(.IDX_W(6), .RES_W(32)) ifm ();
  neuron_sched_if #(.IDX_W(6), .RES_W(32)) if1 ();
  neuron_sched_if #(.IDX_W(6), .RES_W(32)) if16 ();

  assign ifm.START        = start_m;
  assign ifm.ABORT        = abort_m;
  assign ifm.RD_IDX       = rd_m;
  assign ifm.CORE_RESULT  = srm[3];
  assign if1.START        = start_l;
  assign if1.ABORT        = 1'b0;
  assign if1.RD_IDX       = rd_l;
  assign if1.CORE_RESULT  = sr1[0];
  assign if16.START       = start_l;
  assign if16.ABORT       = 1'b0;
  assign if16.RD_IDX      = rd_l;
  assign if16.CORE_RESULT = sr16[15];

  neuron_sched #(.CORE_LAT(4)) u_m (
    .CLK(clk), .RESET(rst), .bus(ifm.slave));
  neuron_sched #(.CORE_LAT(1)) u_l1 (
    .CLK(clk), .RESET(rst), .bus(if1.slave));
  neuron_sched #(.CORE_LAT(16)) u_l16 (
    .CLK(clk), .RESET(rst), .bus(if16.slave));

  function automatic logic [31:0] core_f(
    input int m, input logic [5:0] k);
    case (m)
      0: return 32'd100 + 32'(k);
      1: return (k == 6'd7 || k == 6'd30) ?
                32'h7FFF_0000 : 32'hFFFF_FFFB;
      2: return 32'(-1000) + 32'(k);
      default: return 32'd200 + 32'(k);
    endcase
  endfunction

  always @(posedge clk) begin
    srm[0] <= core_f(mode, ifm.W_SEL);
    for (int i = 1; i < 4; i++) srm[i] <= srm[i-1];
    sr1[0] <= core_f(mode, if1.W_SEL);
    sr16[0] <= core_f(mode, if16.W_SEL);
    for (int i = 1; i < 16; i++) sr16[i] <= sr16[i-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ifm.BUSY !== 1'b0 || ifm.DONE !== 1'b0 ||
        ifm.ISSUE_VLD !== 1'b0 || ifm.IMG_HOLD !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b iv=%b ih=%b want 0",
               ifm.BUSY, ifm.DONE, ifm.ISSUE_VLD, ifm.IMG_HOLD);
    end
    checks++;
    if (ifm.W_SEL !== 6'd0 || ifm.MAX_IDX !== 6'd0 ||
        ifm.MAX_VAL !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got wsel=%0d midx=%0d mval=%h want 0",
               ifm.W_SEL, ifm.MAX_IDX, ifm.MAX_VAL);
    end
    rd_m = 6'd0;
    #1;
    checks++;
    if (ifm.RD_DATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_rd0 got %h want 0", ifm.RD_DATA);
    end
  endtask

  task automatic test_basic();
    int iss = 0, wbad = 0, dn = 0, dc = 0, bbad = 0;
    mode = 0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (ifm.ISSUE_VLD) begin
        iss++;
        if (c > 46 || ifm.W_SEL !== 6'(c - 1)) wbad++;
      end
      if (ifm.DONE) begin dn++; dc = c; end
      if (ifm.BUSY !== (c <= 50)) bbad++;
      if (ifm.IMG_HOLD !== ifm.BUSY) bbad++;
      tick();
    end
    checks++;
    if (iss != 46 || wbad != 0) begin
      errors++;
      $display("FAIL basic_issue got cnt=%0d bad=%0d want 46/0",
               iss, wbad);
    end
    checks++;
    if (dn != 1 || dc != 51) begin
      errors++;
      $display("FAIL basic_done got n=%0d at=%0d want 1 at 51",
               dn, dc);
    end
    checks++;
    if (bbad != 0) begin
      errors++;
      $display("FAIL basic_busy got %0d bad cycles want 0", bbad);
    end
    rd_m = 6'd0; #1;
    checks++;
    if (ifm.RD_DATA !== 32'd100) begin
      errors++;
      $display("FAIL basic_rd0 got %0d want 100", ifm.RD_DATA);
    end
    rd_m = 6'd45; #1;
    checks++;
    if (ifm.RD_DATA !== 32'd145) begin
      errors++;
      $display("FAIL basic_rd45 got %0d want 145", ifm.RD_DATA);
    end
    rd_m = 6'd50; #1;
    checks++;
    if (ifm.RD_DATA !== 32'd0) begin
      errors++;
      $display("FAIL basic_rd50 got %0d want 0", ifm.RD_DATA);
    end
`ifndef NEURON_SCHED_ARGMAX_EN
    checks++;
    if (ifm.MAX_IDX !== 6'd0 || ifm.MAX_VAL !== 32'd0) begin
      errors++;
      $display("FAIL argmax_off got %0d/%h want 0/0",
               ifm.MAX_IDX, ifm.MAX_VAL);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int dn = 0, d1 = 0, d2 = 0;
    logic b52 = 1'b1;
    mode = 3;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      start_m = (c == 10 || c == 51 || c == 52);
      if (c == 52) b52 = ifm.BUSY;
      if (ifm.DONE) begin
        dn++;
        if (dn == 1) d1 = c; else d2 = c;
      end
      tick();
    end
    start_m = 1'b0;
    checks++;
    if (dn != 2 || d1 != 51 || d2 != 103) begin
      errors++;
      $display("FAIL reentry_done got n=%0d at %0d,%0d want 2 at 51,103",
               dn, d1, d2);
    end
    checks++;
    if (b52 !== 1'b0) begin
      errors++;
      $display("FAIL reentry_fin_start got busy=%b want 0", b52);
    end
    rd_m = 6'd30; #1;
    checks++;
    if (ifm.RD_DATA !== 32'd230) begin
      errors++;
      $display("FAIL reentry_rd30 got %0d want 230", ifm.RD_DATA);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    logic [5:0] ws = '0;
    logic b22 = 1'b1;
    logic [31:0] exp [4];
    logic [5:0]  idx [4];
    mode = 0;
    idx[0] = 6'd0;  exp[0] = 32'd100;
    idx[1] = 6'd15; exp[1] = 32'd115;
    idx[2] = 6'd20; exp[2] = 32'd220;
    idx[3] = 6'd45; exp[3] = 32'd245;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      abort_m = (c == 21);
      if (c == 21) ws = ifm.W_SEL;
      if (c == 22) b22 = ifm.BUSY;
      if (ifm.DONE) dn++;
      tick();
    end
    abort_m = 1'b0;
    checks++;
    if (ws !== 6'd20 || b22 !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop got wsel=%0d busy=%b want 20/0",
               ws, b22);
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_done got %0d pulses want 0", dn);
    end
    for (int i = 0; i < 4; i++) begin
      rd_m = idx[i]; #1;
      checks++;
      if (ifm.RD_DATA !== exp[i]) begin
        errors++;
        $display("FAIL abort_rd%0d got %0d want %0d",
                 idx[i], ifm.RD_DATA, exp[i]);
      end
    end
`ifdef NEURON_SCHED_ARGMAX_EN
    checks++;
    if (ifm.MAX_IDX !== 6'd45 || ifm.MAX_VAL !== 32'd245) begin
      errors++;
      $display("FAIL abort_max_hold got %0d/%0d want 45/245",
               ifm.MAX_IDX, ifm.MAX_VAL);
    end
`endif
  endtask

  task automatic test_async_reset();
    int nz = 0, dc = 0;
    mode = 0;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (47) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ifm.BUSY !== 1'b0 || ifm.ISSUE_VLD !== 1'b0 ||
        ifm.IMG_HOLD !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop got busy=%b iv=%b ih=%b want 0",
               ifm.BUSY, ifm.ISSUE_VLD, ifm.IMG_HOLD);
    end
    for (int k = 0; k < 46; k++) begin
      rd_m = 6'(k); #1;
      if (ifm.RD_DATA !== 32'd0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL arst_clear got %0d nonzero want 0", nz);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      if (ifm.DONE) dc = c;
      tick();
    end
    checks++;
    if (dc != 51) begin
      errors++;
      $display("FAIL arst_rerun got done at %0d want 51", dc);
    end
    rd_m = 6'd10; #1;
    checks++;
    if (ifm.RD_DATA !== 32'd110) begin
      errors++;
      $display("FAIL arst_rd10 got %0d want 110", ifm.RD_DATA);
    end
  endtask

`ifdef NEURON_SCHED_ARGMAX_EN
  task automatic test_argmax();
    logic [5:0]  mi = '0;
    logic [31:0] mv = '0;
    logic [5:0]  pi = '0;
    logic [31:0] pv = '0;
    logic [31:0] neg = 32'(-955);
    mode = 1;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      if (ifm.DONE) begin mi = ifm.MAX_IDX; mv = ifm.MAX_VAL; end
      tick();
    end
    checks++;
    if (mi !== 6'd7 || mv !== 32'h7FFF_0000) begin
      errors++;
      $display("FAIL argmax_tie got %0d/%h want 7/7fff0000", mi, mv);
    end
    mode = 2;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      if (c == 50) begin pi = ifm.MAX_IDX; pv = ifm.MAX_VAL; end
      if (ifm.DONE) begin mi = ifm.MAX_IDX; mv = ifm.MAX_VAL; end
      tick();
    end
    checks++;
    if (pi !== 6'd7 || pv !== 32'h7FFF_0000) begin
      errors++;
      $display("FAIL argmax_hold got %0d/%h want 7/7fff0000", pi, pv);
    end
    checks++;
    if (mi !== 6'd45 || mv !== neg) begin
      errors++;
      $display("FAIL argmax_neg got %0d/%h want 45/%h", mi, mv, neg);
    end
  endtask
`endif

  task automatic test_latency();
    int d1 = 0, d16 = 0, bad1 = 0, bad16 = 0;
    mode = 0;
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (if1.DONE) d1 = c;
      if (if16.DONE) d16 = c;
      tick();
    end
    checks++;
    if (d1 != 48) begin
      errors++;
      $display("FAIL lat1_done got %0d want 48", d1);
    end
    checks++;
    if (d16 != 63) begin
      errors++;
      $display("FAIL lat16_done got %0d want 63", d16);
    end
    for (int k = 0; k < 46; k++) begin
      rd_l = 6'(k); #1;
      if (if1.RD_DATA !== 32'd100 + 32'(k)) bad1++;
      if (if16.RD_DATA !== 32'd100 + 32'(k)) bad16++;
    end
    checks++;
    if (bad1 != 0) begin
      errors++;
      $display("FAIL lat1_entries got %0d bad want 0", bad1);
    end
    checks++;
    if (bad16 != 0) begin
      errors++;
      $display("FAIL lat16_entries got %0d bad want 0", bad16);
    end
    rd_l = 6'd46; #1;
    checks++;
    if (if1.RD_DATA !== 32'd0 || if16.RD_DATA !== 32'd0) begin
      errors++;
      $display("FAIL lat_rd46 got %0d,%0d want 0",
               if1.RD_DATA, if16.RD_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_async_reset();
`ifdef NEURON_SCHED_ARGMAX_EN
    test_argmax();
`endif
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
